// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and types for the unrolled FIR datapath
package fir_pkg;

   // Default sample width of the filter datapath
   localparam int SAMPLE_W = 32;

   // Number of parallel lanes produced per block
   localparam int UNROLL = 3;

   // Lane index within a block
   typedef logic [1:0] lane_t;

   // Index of the last lane emitted from a block
   localparam lane_t LANE_LAST = lane_t'(UNROLL - 1);

endpackage

// File: rtl/fir3x_out_serializer_if.sv
// rtl/fir3x_out_serializer_if.sv - block input / serial output handshake bundle
interface fir3x_out_serializer_if
   import fir_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W,
   parameter int DEPTH = 4
);

   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        in_y0;
   logic [WIDTH-1:0]        in_y1;
   logic [WIDTH-1:0]        in_y2;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;
   lane_t                   out_lane;
   logic [$clog2(DEPTH):0]  level;

   // Serializer side
   modport slave (
      input  in_valid, in_y0, in_y1, in_y2, out_ready,
      output in_ready, out_valid, out_data, out_lane, level
   );

   // Producer / sink side
   modport master (
      output in_valid, in_y0, in_y1, in_y2, out_ready,
      input  in_ready, out_valid, out_data, out_lane, level
   );

endinterface

// File: rtl/fir_blk_fifo.sv
// rtl/fir_blk_fifo.sv - FIFO of whole 3-lane sample blocks with occupancy level
module fir_blk_fifo
   import fir_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [UNROLL*WIDTH-1:0]      push_data,
   input  logic                         pop,
   output logic [UNROLL*WIDTH-1:0]      head_data,
   output logic [$clog2(DEPTH):0]       level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [UNROLL*WIDTH-1:0] mem_q [DEPTH];
   logic [UNROLL*WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]        level_q,  level_d;

   // Pointer and level update; push and pop in the same cycle leave the level unchanged.
   // Callers never push when full nor pop when empty.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // Storage write into the current write slot
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
      end
   end

   // Control registers; reset empties the FIFO and wins over push/pop
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Block storage needs no reset: contents are only observed while level is non-zero
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_data = mem_q[rd_ptr_q];
   assign level     = level_q;

endmodule

// File: rtl/fir3x_out_serializer.sv
// rtl/fir3x_out_serializer.sv - buffers 3-lane FIR output blocks and emits one sample per beat
module fir3x_out_serializer
   import fir_pkg::*;
#(
   parameter int WIDTH = SAMPLE_W,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   fir3x_out_serializer_if.slave   bus
);

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [UNROLL*WIDTH-1:0] head_data;
   logic [LVL_W-1:0]        level;
   logic                    full;
   logic                    out_valid;
   logic                    push;
   logic                    beat;
   logic                    pop;
   lane_t                   lane_q, lane_d;

   // Input acceptance depends only on the registered level, never on out_ready
   assign full      = (level == LVL_W'(DEPTH));
   assign push      = bus.in_valid && !full;
   assign out_valid = (level != '0);
   assign beat      = out_valid && bus.out_ready;
   assign pop       = beat && (lane_q == LANE_LAST);

   fir_blk_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({bus.in_y0, bus.in_y1, bus.in_y2}),
      .pop       (pop),
      .head_data (head_data),
      .level     (level)
   );

   // Lane counter advances on every accepted beat and wraps after the last lane
   always_comb begin
      lane_d = lane_q;
      if (beat) begin
         if (lane_q == LANE_LAST) begin
            lane_d = '0;
         end else begin
            lane_d = lane_q + lane_t'(1);
         end
      end
   end

   // Lane counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         lane_q <= '0;
      end else begin
         lane_q <= lane_d;
      end
   end

   // Output mux selects the current lane of the head block; zeros while empty
   always_comb begin
      bus.out_data = '0;
      bus.out_lane = '0;
      if (out_valid) begin
         bus.out_lane = lane_q;
         case (lane_q)
            2'd0:    bus.out_data = head_data[3*WIDTH-1:2*WIDTH];
            2'd1:    bus.out_data = head_data[2*WIDTH-1:WIDTH];
            default: bus.out_data = head_data[WIDTH-1:0];
         endcase
      end
   end

   assign bus.in_ready  = !full;
   assign bus.out_valid = out_valid;
   assign bus.level     = level;

endmodule

// File: tb/tb_fir3x_out_serializer.sv
// tb/tb_fir3x_out_serializer.sv - randomized and directed bench against a sample-queue model
module tb_fir3x_out_serializer;

   localparam int W = 32;
   localparam int D = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fir3x_out_serializer_if #(.WIDTH(W), .DEPTH(D)) bus ();

   fir3x_out_serializer #(.WIDTH(W), .DEPTH(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Model: every pending sample in emission order; blocks are 3 consecutive entries
   logic [W-1:0] mq [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Outputs derived from the pending-sample count: level is whole-or-partial blocks,
   // lane is position of the head sample inside its block
   task automatic check_outputs();
      int s;
      int lvl;
      s   = mq.size();
      lvl = (s + 2) / 3;
      check("level",     64'(bus.level),     64'(lvl));
      check("in_ready",  64'(bus.in_ready),  64'(lvl != D));
      check("out_valid", 64'(bus.out_valid), 64'(s != 0));
      check("out_data",  64'(bus.out_data),  (s != 0) ? 64'(mq[0]) : 64'(0));
      check("out_lane",  64'(bus.out_lane),  (s != 0) ? 64'((3 - s % 3) % 3) : 64'(0));
   endtask

   task automatic cycle(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input bit r, output bit acc);
      bit beat;
      bus.in_valid  = v;
      bus.in_y0     = a;
      bus.in_y1     = b;
      bus.in_y2     = c;
      bus.out_ready = r;
      #2;
      check_outputs();
      acc  = v && (((mq.size() + 2) / 3) != D);
      beat = (mq.size() != 0) && r;
      @(posedge clk);
      #1;
      if (beat) void'(mq.pop_front());
      if (acc) begin
         mq.push_back(a);
         mq.push_back(b);
         mq.push_back(c);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      mq.delete();
   endtask

   initial begin
      bit acc;
      bit held;
      bit b5_done;
      logic [W-1:0] ra, rb, rc;

      bus.in_valid  = 1'b0;
      bus.in_y0     = '0;
      bus.in_y1     = '0;
      bus.in_y2     = '0;
      bus.out_ready = 1'b0;
      reset         = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // Idle after reset
      cycle(0, 0, 0, 0, 0, acc);
      check("rst_level", 64'(bus.level), 64'(0));

      // Single block straight through
      cycle(1, 10, -32'sd7, 30, 1, acc);
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, acc);

      // Fill to DEPTH with the sink stalled, then hold block 5
      for (int k = 0; k < 4; k++) cycle(1, 3*k+1, 3*k+2, 3*k+3, 0, acc);
      for (int i = 0; i < 3; i++) cycle(1, 13, 14, 15, 0, acc);
      check("full_level", 64'(bus.level), 64'(4));
      check("full_ready", 64'(bus.in_ready), 64'(0));
      b5_done = 1'b0;
      for (int i = 0; i < 40 && mq.size() != 0; i++) begin
         cycle(!b5_done, 13, 14, 15, 1, acc);
         if (acc) b5_done = 1'b1;
      end
      check("b5_accepted", 64'(b5_done), 64'(1));
      cycle(0, 0, 0, 0, 1, acc);

      // Stall pattern in the middle of a block
      cycle(1, 100, 200, 300, 0, acc);
      cycle(0, 0, 0, 0, 1, acc);
      cycle(0, 0, 0, 0, 0, acc);
      check("stall_data", 64'(bus.out_data), 64'(200));
      cycle(0, 0, 0, 0, 0, acc);
      cycle(0, 0, 0, 0, 1, acc);
      cycle(0, 0, 0, 0, 1, acc);
      cycle(0, 0, 0, 0, 1, acc);

      // Push coinciding with the final-lane pop
      cycle(1, 1, 2, 3, 0, acc);
      cycle(0, 0, 0, 0, 1, acc);
      cycle(0, 0, 0, 0, 1, acc);
      cycle(1, 4, 5, 6, 1, acc);
      check("simul_level", 64'(bus.level), 64'(1));
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, acc);

      // Reset mid-block with a second block queued; reset wins over push and pop
      cycle(1, 7, 8, 9, 0, acc);
      cycle(1, 1, 1, 1, 1, acc);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      do_reset();
      cycle(0, 0, 0, 0, 1, acc);
      check("post_rst_level", 64'(bus.level), 64'(0));
      cycle(1, 20, 21, 22, 1, acc);
      check("fresh_data", 64'(bus.out_data), 64'(20));
      check("fresh_lane", 64'(bus.out_lane), 64'(0));
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, acc);

      // Random traffic; a presented block is held until accepted
      held = 1'b0;
      ra = '0; rb = '0; rc = '0;
      for (int i = 0; i < 500; i++) begin
         bit v;
         if (held) begin
            v = 1'b1;
         end else begin
            v  = ($urandom % 4) != 0;
            ra = $urandom;
            rb = $urandom;
            rc = $urandom;
         end
         cycle(v, ra, rb, rc, ($urandom % 3) != 0, acc);
         held = v && !acc;
      end
      for (int i = 0; i < 60 && mq.size() != 0; i++) begin
         cycle(held, ra, rb, rc, 1, acc);
         if (acc) held = 1'b0;
      end
      cycle(0, 0, 0, 0, 1, acc);
      check("final_level", 64'(bus.level), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
